// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave timer front end.
package microwave_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ENTRY,
    ST_NORM,
    ST_LOCKED
  } state_t;

  localparam int SECS_PER_MIN   = 60;
  localparam int MAX_TOTAL_SECS = 599;

endpackage

// File: rtl/strobe_sync_edge.sv
// Synchronises an asynchronous active-low strobe and flags each falling edge for one cycle.
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strb_n_i,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;

  // prev_q only sees a high once real samples reach the last stage, so a strobe
  // already low when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strb_n_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1] & fill_q[SYNC_STAGES-1];
    end
  end

  assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_digit_receiver.sv
// Shifts keypad digits into an M:SS entry, normalises it on commit and publishes
// BCD digits plus total seconds; entry is frozen while lock is high.
module keypad_digit_receiver
  import microwave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MINS    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       clearn,
  input  logic       lock,
  input  logic       commit,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] digit_count,
  output logic [9:0] total_secs,
  output logic       time_valid,
  output logic       commit_done,
  output logic       err
);

  localparam bcd_t MAX_M = bcd_t'(MAX_MINS);

  state_t     state_q;
  bcd_t       mins_q, tens_q, ones_q;
  logic [1:0] cnt_q;
  logic [9:0] tot_q;
  logic       tv_q, done_q, err_q;
  logic       pend_dig_q, pend_clr_q;
  bcd_t       pend_dat_q;

  logic dig_fall;

  strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_loadn_sync (
    .clk_i    (clk),
    .rst_i    (rst),
    .strb_n_i (loadn),
    .fall_o   (dig_fall)
  );

  // Events deferred from the NORM cycle are replayed ahead of live inputs.
  logic dig_evt, dig_ok, dig_bad, clr_req;
  bcd_t dig_val;

  assign dig_evt = pend_dig_q | dig_fall;
  assign dig_val = pend_dig_q ? pend_dat_q : bcd_t'(data);
  assign dig_ok  = dig_evt && (dig_val <= 4'd9);
  assign dig_bad = dig_evt && (dig_val > 4'd9);
  assign clr_req = pend_clr_q | ~clearn;

  logic [6:0] s_raw, s_adj;
  bcd_t       m_adj, m_fin, tens_n, ones_n;
  logic [5:0] s_fin;
  logic [9:0] tot_n;
  logic [1:0] cnt_n;

  always_comb begin
    s_raw = 7'(tens_q) * 7'd10 + 7'(ones_q);
    s_adj = s_raw;
    m_adj = mins_q;
    if (s_raw >= 7'(SECS_PER_MIN)) begin
      s_adj = s_raw - 7'(SECS_PER_MIN);
      m_adj = mins_q + 4'd1;
    end
    m_fin = m_adj;
    s_fin = 6'(s_adj);
    if (m_adj > MAX_M) begin
      m_fin = MAX_M;
      s_fin = 6'd59;
    end
    tens_n = 4'(s_fin / 6'd10);
    ones_n = 4'(s_fin % 6'd10);
    tot_n  = 10'(m_fin) * 10'(SECS_PER_MIN) + 10'(s_fin);
    cnt_n  = (m_fin != 4'd0) ? 2'd3 : (tens_n != 4'd0) ? 2'd2 : (ones_n != 4'd0) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      mins_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      cnt_q      <= '0;
      tot_q      <= '0;
      tv_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pend_dig_q <= 1'b0;
      pend_clr_q <= 1'b0;
      pend_dat_q <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pend_dig_q <= 1'b0;
      pend_clr_q <= 1'b0;
      case (state_q)
        ST_EMPTY, ST_ENTRY: begin
          if (lock) begin
            state_q <= ST_LOCKED;
          end else if (clr_req) begin
            mins_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            tv_q    <= 1'b0;
            state_q <= ST_EMPTY;
          end else if (state_q == ST_EMPTY) begin
            if (dig_bad || commit) begin
              err_q <= 1'b1;
            end else if (dig_ok && dig_val != 4'd0) begin
              ones_q  <= dig_val;
              cnt_q   <= 2'd1;
              tv_q    <= 1'b0;
              state_q <= ST_ENTRY;
            end
          end else if (dig_bad) begin
            err_q <= 1'b1;
            if (commit) state_q <= ST_NORM;
          end else if (commit) begin
            state_q <= ST_NORM;
            if (dig_ok) begin
              pend_dig_q <= 1'b1;
              pend_dat_q <= dig_val;
            end
          end else if (dig_ok) begin
            mins_q <= tens_q;
            tens_q <= ones_q;
            ones_q <= dig_val;
            cnt_q  <= (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            tv_q   <= 1'b0;
          end
        end
        ST_NORM: begin
          mins_q  <= m_fin;
          tens_q  <= tens_n;
          ones_q  <= ones_n;
          cnt_q   <= cnt_n;
          tot_q   <= tot_n;
          tv_q    <= 1'b1;
          done_q  <= 1'b1;
          state_q <= lock ? ST_LOCKED : ST_ENTRY;
          if (dig_bad) begin
            err_q <= 1'b1;
          end else if (dig_ok) begin
            pend_dig_q <= 1'b1;
            pend_dat_q <= dig_val;
          end
          pend_clr_q <= clr_req;
        end
        ST_LOCKED: begin
          if (!lock) state_q <= (cnt_q != 2'd0) ? ST_ENTRY : ST_EMPTY;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign mins        = mins_q;
  assign sec_tens    = tens_q;
  assign sec_ones    = ones_q;
  assign digit_count = cnt_q;
  assign total_secs  = tot_q;
  assign time_valid  = tv_q;
  assign commit_done = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_keypad_digit_receiver.sv
// Table-driven digit entry and commit vectors plus hand sequences, with a commit scoreboard.
module tb_keypad_digit_receiver;

  logic       clk = 1'b0;
  logic       rst, loadn, clearn, lock, commit;
  logic [3:0] data;
  logic [3:0] mins, sec_tens, sec_ones;
  logic [1:0] digit_count;
  logic [9:0] total_secs;
  logic       time_valid, commit_done, err;

  keypad_digit_receiver #(.SYNC_STAGES(2), .MAX_MINS(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .loadn       (loadn),
    .clearn      (clearn),
    .lock        (lock),
    .commit      (commit),
    .mins        (mins),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .digit_count (digit_count),
    .total_secs  (total_secs),
    .time_valid  (time_valid),
    .commit_done (commit_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digs;
    int          n;
    bit          do_cm;
    int          pm, pt, po, pc;
    int          cm, ct, co, tot;
  } vec_t;

  typedef struct {
    int m, t, o, tot;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  int   done_seen = 0;
  int   done_exp = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_digits(input string nm, input int m, input int t, input int o, input int c);
    check({nm, "_mins"}, int'(mins), m);
    check({nm, "_tens"}, int'(sec_tens), t);
    check({nm, "_ones"}, int'(sec_ones), o);
    if (c >= 0) check({nm, "_count"}, int'(digit_count), c);
  endtask

  task automatic strobe(input logic [3:0] d);
    @(posedge clk); #1;
    data  = d;
    loadn = 1'b0;
    repeat (4) @(posedge clk);
    #1 loadn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1 clearn = 1'b0;
    @(posedge clk); #1 clearn = 1'b1;
  endtask

  task automatic commit_pulse();
    @(posedge clk); #1 commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
  endtask

  task automatic commit_check(input string nm, input exp_t e);
    int lat;
    sb.push_back(e);
    done_exp++;
    lat = 99;
    @(posedge clk); #1 commit = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      commit = 1'b0;
      if (commit_done) begin
        lat = i;
        break;
      end
    end
    check({nm, "_latency"}, lat, 2);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard: each commit_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_seen++;
      if (commit_done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_commit_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_mins", int'(mins), e.m);
          check("sb_tens", int'(sec_tens), e.t);
          check("sb_ones", int'(sec_ones), e.o);
          check("sb_total", int'(total_secs), e.tot);
          check("sb_time_valid", int'(time_valid), 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  vec_t        vt[8];
  logic [15:0] dg;

  initial begin
    vt[0] = '{16'h0130, 4, 1'b1, 1, 3, 0, 3, 1, 3, 0, 90};
    vt[1] = '{16'h1750, 3, 1'b1, 1, 7, 5, 3, 2, 1, 5, 135};
    vt[2] = '{16'h9990, 3, 1'b1, 9, 9, 9, 3, 9, 5, 9, 599};
    vt[3] = '{16'h1234, 4, 1'b0, 2, 3, 4, 3, 2, 3, 4, 0};
    vt[4] = '{16'h7500, 2, 1'b1, 0, 7, 5, 2, 1, 1, 5, 75};
    vt[5] = '{16'h5000, 1, 1'b1, 0, 0, 5, 1, 0, 0, 5, 5};
    vt[6] = '{16'h9600, 3, 1'b1, 9, 6, 0, 3, 9, 5, 9, 599};
    vt[7] = '{16'h0000, 2, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; loadn = 1'b1; clearn = 1'b1; lock = 1'b0; commit = 1'b0; data = 4'd0;
    #12;
    check_digits("reset", 0, 0, 0, 0);
    check("reset_total", int'(total_secs), 0);
    check("reset_tv", int'(time_valid), 0);
    check("reset_done", int'(commit_done), 0);
    check("reset_err", int'(err), 0);
    #11 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      dg = vt[v].digs;
      clear_pulse();
      for (int i = 0; i < vt[v].n; i++) strobe(dg[15-4*i -: 4]);
      check_digits($sformatf("v%0d_pre", v), vt[v].pm, vt[v].pt, vt[v].po, vt[v].pc);
      if (vt[v].do_cm) begin
        commit_check($sformatf("v%0d", v), '{vt[v].cm, vt[v].ct, vt[v].co, vt[v].tot});
        check_digits($sformatf("v%0d_post", v), vt[v].cm, vt[v].ct, vt[v].co, -1);
        check($sformatf("v%0d_total", v), int'(total_secs), vt[v].tot);
        check($sformatf("v%0d_tv", v), int'(time_valid), 1);
      end else begin
        check($sformatf("v%0d_tv", v), int'(time_valid), 0);
      end
    end

    // Invalid digit code is rejected without disturbing the entry.
    strobe(4'd2); strobe(4'd3); strobe(4'd4);
    strobe(4'd12);
    err_exp++;
    check("bad_digit_err", err_seen, err_exp);
    check_digits("bad_digit", 2, 3, 4, 3);

    // Digit landing in the NORM cycle is held and applied afterwards.
    clear_pulse();
    strobe(4'd1); strobe(4'd7); strobe(4'd5);
    sb.push_back('{2, 1, 5, 135});
    done_exp++;
    @(posedge clk); #1 data = 4'd3; loadn = 1'b0;
    @(posedge clk); #1 commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
    repeat (3) @(posedge clk);
    #1 loadn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_digits("norm_overlap", 1, 5, 3, 3);
    check("norm_overlap_tv", int'(time_valid), 0);
    check("norm_overlap_done", done_seen, done_exp);

    // Lock freezes the entry and suppresses digits, clear and commit.
    clear_pulse();
    strobe(4'd4); strobe(4'd5); strobe(4'd0);
    commit_check("lock_pre", '{4, 5, 0, 290});
    @(posedge clk); #1 lock = 1'b1;
    repeat (2) @(posedge clk);
    strobe(4'd7);
    clear_pulse();
    commit_pulse();
    strobe(4'd13);
    repeat (3) @(posedge clk);
    #1;
    check_digits("locked", 4, 5, 0, 3);
    check("locked_total", int'(total_secs), 290);
    check("locked_tv", int'(time_valid), 1);
    check("locked_err", err_seen, err_exp);
    lock = 1'b0;
    repeat (2) @(posedge clk);
    strobe(4'd7);
    check_digits("unlock", 5, 0, 7, 3);
    check("unlock_tv", int'(time_valid), 0);

    // Clear coinciding with a digit event wins; commit on empty entry errs.
    @(posedge clk); #1 data = 4'd3; loadn = 1'b0; clearn = 1'b0;
    repeat (4) @(posedge clk);
    #1 loadn = 1'b1; clearn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_digits("clear_digit", 0, 0, 0, 0);
    check("clear_digit_tv", int'(time_valid), 0);
    commit_pulse();
    err_exp++;
    repeat (3) @(posedge clk);
    #1;
    check("empty_commit_err", err_seen, err_exp);
    check("empty_commit_done", done_seen, done_exp);

    // Reset mid-strobe: async clear, and no event until the strobe re-arms.
    strobe(4'd8);
    check_digits("pre_rst", 0, 0, 8, 1);
    @(posedge clk); #1 data = 4'd6; loadn = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check_digits("async_rst", 0, 0, 0, 0);
    check("async_rst_total", int'(total_secs), 0);
    check("async_rst_tv", int'(time_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_digits("held_low", 0, 0, 0, 0);
    loadn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_digits("released", 0, 0, 0, 0);
    strobe(4'd6);
    check_digits("rearmed", 0, 0, 6, 1);

    check("sb_drained", sb.size(), 0);
    check("done_total", done_seen, done_exp);
    check("err_total", err_seen, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_digit_receiver.md
Name: keypad_digit_receiver

Overview:
- Receiving end of the keypad encoder's digit interface: takes the 4-bit `data` code strobed by active-low `loadn` and shifts digits into a 3-digit M:SS entry register.
- On `commit` it normalises the entry (e.g. 1:75 -> 2:15) and publishes BCD digits plus a binary total in seconds to the countdown timer.
- Entry is frozen while the magnetron control asserts `lock`.

Parameters:
- SYNC_STAGES, 2: flops in the `loadn` synchroniser (min 2).
- MAX_MINS, 9: saturation value for the minutes digit after normalisation.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- data  in  4  BCD digit code from the encoder; stable while `loadn` is low
- loadn  in  1  active-low digit strobe from the encoder; asynchronous, >= SYNC_STAGES+1 clk wide
- clearn  in  1  synchronous active-low entry clear
- lock  in  1  high while cooking; blocks digits, clear and commit
- commit  in  1  single-cycle request to normalise and publish
- mins  out  4  minutes BCD digit
- sec_tens  out  4  tens-of-seconds BCD digit
- sec_ones  out  4  ones-of-seconds BCD digit
- digit_count  out  2  number of significant digits entered (0..3)
- total_secs  out  10  normalised time in seconds (0..599), valid when `time_valid` is high
- time_valid  out  1  high from `commit_done` until the next entry change or clear
- commit_done  out  1  one-cycle pulse when normalised values are published
- err  out  1  one-cycle pulse: digit code > 9 rejected, or commit attempted on an empty entry

Behaviour:
- Reset (async, rst=1): all digit registers = 0; digit_count = 0; total_secs = 0; time_valid, commit_done and err = 0; FSM = EMPTY; synchroniser flops = 1.
- Strobe detection:
  - `loadn` passes through the SYNC_STAGES synchroniser.
  - A falling edge of the synchronised signal is a digit event.
  - `data` is captured in the same cycle as the edge.
  - One event per strobe regardless of strobe width.
- FSM states: EMPTY, ENTRY, NORM, LOCKED.
- EMPTY:
  - Digit 0 is ignored (no leading zeros).
  - Digit 1..9: sec_ones = d, count = 1 -> ENTRY.
- ENTRY, digit event d <= 9:
  - Shift: mins <= sec_tens, sec_tens <= sec_ones, sec_ones <= d.
  - count = min(count+1, 3).
  - When 3 digits are already held, the old `mins` is discarded.
  - time_valid <= 0.
- Digit event with d > 9, any state except LOCKED: digit dropped, err pulse, no other change.
- clearn = 0, not locked: all digits and count -> 0, time_valid <= 0, FSM -> EMPTY. Same-cycle clear and digit: clear wins and the digit is lost.
- commit in ENTRY -> NORM. In NORM (exactly one cycle), with s = 10*sec_tens + sec_ones:
  - If s >= 60: s -= 60 and mins += 1.
  - If mins > MAX_MINS: saturate to MAX_MINS:59.
  - Write the normalised digits back, total_secs = 60*mins + s, time_valid <= 1, pulse commit_done, return to ENTRY.
  - Latency: commit_done is 2 clk after the `commit` cycle.
- commit in EMPTY: err pulse, no state change.
- Digit or clear arriving while in NORM is held for one cycle and applied in the following cycle. Digits are never lost.
- lock = 1 from any state -> LOCKED; the NORM update completes first.
- LOCKED:
  - Digit events, clearn and commit are ignored with no err.
  - Outputs hold.
  - lock = 0 returns to ENTRY if count > 0, else EMPTY.
- Mid-strobe reset: synchroniser restarts at 1, so a strobe still low after reset release produces no event until it rises and falls again.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package `microwave_pkg`:
  - typedef bcd_t (4 bits)
  - FSM state enum
  - constants SECS_PER_MIN = 60 and MAX_TOTAL_SECS = 599
- One sub-module, `strobe_sync_edge`: SYNC_STAGES synchroniser plus falling-edge detector, also reusable for the start/stop buttons.
- The normalisation arithmetic stays inline in this block.

Test Plan:
- Reset, then digits 0,1,3,0 -> leading 0 ignored; result 1:30, count 3; commit -> commit_done 2 clk later, total_secs 90, time_valid 1.
- Digits 1,7,5, commit -> digits 2:15, total_secs 135; digits 9,9,9, commit -> saturate 9:59, total_secs 599.
- Digits 1,2,3,4 -> 2:34 (oldest dropped), count 3; data = 12 strobe -> err pulse, digits unchanged.
- Entry 4:50, lock=1, then digits, clearn and commit applied -> all outputs held, no err; lock=0 -> FSM ENTRY, next digit 7 gives 5:07.
- clearn low in the same cycle as a digit event -> all digits 0, count 0, time_valid 0; commit afterwards -> err pulse.
- rst asserted while loadn is low mid-strobe -> outputs 0 immediately (async), no digit event until loadn rises and falls again.
